// File: rtl/dcache_line_buffer_pkg.sv
// Shared types and widths for the data-cache line buffer.
// The line is assembled from BEAT_W-wide memory beats; the array is SET_W-addressed.
package dcache_line_buffer_pkg;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int SET_W  = 4;
  localparam int MASK_W = LINE_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FILL_WR,
    S_WB_RD,
    S_WB_CAP,
    S_WB_SEND,
    S_DONE
  } state_t;

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/dcache_line_buffer.sv
// Line buffer between memory beats and the data array: fill (beats -> array write) and writeback (array read -> beats).
// DCACHE_CRIT_WORD_EN adds a one-cycle critical-word forward during fills.
module dcache_line_buffer
  import dcache_line_buffer_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_req,
  input  logic              wb_req,
  input  logic [SET_W-1:0]  set_idx,
  output logic              busy,
  output logic              done,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [BEAT_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic              arr_csb,
  output logic              arr_web,
  output logic [MASK_W-1:0] arr_wmask,
  output logic [SET_W-1:0]  arr_addr,
  output logic [LINE_W-1:0] arr_din,
  input  logic [LINE_W-1:0] arr_dout
`ifdef DCACHE_CRIT_WORD_EN
  ,
  input  logic [1:0]        crit_word,
  output logic              crit_valid,
  output logic [BEAT_W-1:0] crit_data
`endif
);

  localparam int CNT_W = cnt_width(BEATS);

  state_t              r_state;
  logic [SET_W-1:0]    r_set;
  logic [LINE_W-1:0]   r_line;
  logic [CNT_W-1:0]    r_k;
  logic                r_busy;
  logic                r_done;
  logic                r_csb;
  logic                r_web;
  logic [MASK_W-1:0]   r_wmask;
  logic                r_wvalid;

  logic                w_last;
  logic                w_clr;
  logic                w_inc;

  assign w_last = (r_k == CNT_W'(BEATS - 1));
  assign w_clr  = (r_state == S_IDLE) || (r_state == S_WB_CAP);
  assign w_inc  = ((r_state == S_FILL) && mem_rvalid) ||
                  ((r_state == S_WB_SEND) && mem_wready);

  // Beat index wraps after the last beat so the next transfer starts at slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k <= '0;
    end else if (w_clr) begin
      r_k <= '0;
    end else if (w_inc) begin
      r_k <= w_last ? '0 : r_k + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_set    <= '0;
      r_line   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_csb    <= 1'b1;
      r_web    <= 1'b1;
      r_wmask  <= '0;
      r_wvalid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wb_req) begin
            r_state <= S_WB_RD;
            r_set   <= set_idx;
            r_busy  <= 1'b1;
            r_csb   <= 1'b0;
            r_web   <= 1'b1;
          end else if (fill_req) begin
            r_state <= S_FILL;
            r_set   <= set_idx;
            r_busy  <= 1'b1;
          end
        end
        S_FILL: begin
          if (mem_rvalid) begin
            r_line[int'(r_k)*BEAT_W +: BEAT_W] <= mem_rdata;
            if (w_last) begin
              r_state <= S_FILL_WR;
              r_csb   <= 1'b0;
              r_web   <= 1'b0;
              r_wmask <= '1;
            end
          end
        end
        S_FILL_WR: begin
          r_state <= S_DONE;
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_wmask <= '0;
          r_done  <= 1'b1;
        end
        S_WB_RD: begin
          r_state <= S_WB_CAP;
          r_csb   <= 1'b1;
        end
        S_WB_CAP: begin
          r_line   <= arr_dout;
          r_state  <= S_WB_SEND;
          r_wvalid <= 1'b1;
        end
        S_WB_SEND: begin
          if (mem_wready && w_last) begin
            r_state  <= S_DONE;
            r_wvalid <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign arr_csb    = r_csb;
  assign arr_web    = r_web;
  assign arr_wmask  = r_wmask;
  assign arr_addr   = r_set;
  assign arr_din    = r_line;
  assign mem_wvalid = r_wvalid;
  assign mem_wdata  = r_line[int'(r_k)*BEAT_W +: BEAT_W];

`ifdef DCACHE_CRIT_WORD_EN
  logic [1:0]        r_crit_word;
  logic              r_crit_valid;
  logic [BEAT_W-1:0] r_crit_data;
  logic              w_crit_hit;

  assign w_crit_hit = (r_state == S_FILL) && mem_rvalid && (r_k == CNT_W'(r_crit_word));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crit_word  <= '0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
    end else begin
      if ((r_state == S_IDLE) && fill_req && !wb_req) r_crit_word <= crit_word;
      r_crit_valid <= w_crit_hit;
      if (w_crit_hit) r_crit_data <= mem_rdata;
    end
  end

  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;
`endif

endmodule

// File: tb/tb_dcache_line_buffer.sv
// Randomized bench for dcache_line_buffer with a transaction-timeline model and a small array model.
module tb_dcache_line_buffer;
  import dcache_line_buffer_pkg::*;

  localparam int BEATS = 4;
  localparam int BIG   = 32'h3fffffff;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fill_req = 1'b0;
  logic              wb_req = 1'b0;
  logic [3:0]        set_idx = '0;
  logic              busy, done;
  logic [63:0]       mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic [63:0]       mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready = 1'b0;
  logic              arr_csb, arr_web;
  logic [31:0]       arr_wmask;
  logic [3:0]        arr_addr;
  logic [255:0]      arr_din;
  logic [255:0]      arr_dout = '0;
`ifdef DCACHE_CRIT_WORD_EN
  logic [1:0]        crit_word = '0;
  logic              crit_valid;
  logic [63:0]       crit_data;
`endif

  always #5 clk = ~clk;

  dcache_line_buffer #(.BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .fill_req(fill_req), .wb_req(wb_req), .set_idx(set_idx),
    .busy(busy), .done(done), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .arr_csb(arr_csb), .arr_web(arr_web), .arr_wmask(arr_wmask), .arr_addr(arr_addr),
    .arr_din(arr_din), .arr_dout(arr_dout)
`ifdef DCACHE_CRIT_WORD_EN
    , .crit_word(crit_word), .crit_valid(crit_valid), .crit_data(crit_data)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Synchronous single-port array stand-in with byte write mask.
  logic [255:0] arr_mem [16];
  logic         pl_en = 1'b0;
  logic [3:0]   pl_idx = '0;
  logic [255:0] pl_val = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      arr_mem[pl_idx] <= pl_val;
    end else if (!arr_csb) begin
      if (!arr_web) begin
        for (int b = 0; b < 32; b++)
          if (arr_wmask[b]) arr_mem[arr_addr][8*b +: 8] <= arr_din[8*b +: 8];
      end else begin
        arr_dout <= arr_mem[arr_addr];
      end
    end
  end

  // Model: one transaction at a time, described by its accept cycle and derived event cycles.
  int           cyc = 0;
  bit           m_active = 1'b0;
  bit           m_is_wb = 1'b0;
  int           m_acc = 0, m_wr = BIG, m_done = BIG, m_k = 0;
  logic [3:0]   m_set = '0;
  logic [255:0] m_line = '0, m_wbline = '0;
  int           m_crit_cyc = -10;
  logic [1:0]   m_crit_word = '0;
  logic [63:0]  m_crit_data = '0;

  int           wr_count = 0, done_count = 0;
  int           last_done_cyc = 0, last_beat4_cyc = 0, last_acc_cyc = 0;
  logic [255:0] last_wr_din = '0;
  logic [3:0]   last_wr_addr = '0;
  logic [31:0]  last_wr_mask = '0;
  logic [63:0]  last_crit_data = '0;
  logic [63:0]  obs_beats [$];

  always @(negedge clk) begin
    bit was_active, exp_wr, exp_rd, exp_wv, exp_done, exp_busy;
    cyc++;
    if (rst) begin
      m_active   = 1'b0;
      m_crit_cyc = -10;
    end else begin
      was_active = m_active;
      exp_wr   = m_active && !m_is_wb && (cyc == m_wr);
      exp_rd   = m_active && m_is_wb && (cyc == m_acc + 1);
      exp_wv   = m_active && m_is_wb && (cyc >= m_acc + 3) && (m_k < BEATS);
      exp_done = m_active && (cyc == m_done);
      exp_busy = m_active && (cyc > m_acc) && (cyc <= m_done);

      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("arr_csb", arr_csb, !(exp_wr || exp_rd));
      chk("arr_web", arr_web, !exp_wr);
      chk("arr_wmask", arr_wmask, exp_wr ? 32'hFFFF_FFFF : 32'h0);
      chk("mem_wvalid", mem_wvalid, exp_wv);
      if (exp_wr || exp_rd) chk("arr_addr", arr_addr, m_set);
      if (exp_wr) chk("arr_din", arr_din, m_line);

      if (!arr_csb && !arr_web) begin
        wr_count++;
        last_wr_din  = arr_din;
        last_wr_addr = arr_addr;
        last_wr_mask = arr_wmask;
      end
      if (done) begin
        done_count++;
        last_done_cyc = cyc;
      end

      if (exp_wv) begin
        chk("mem_wdata", mem_wdata, m_wbline[64*m_k +: 64]);
        if (mem_wready) begin
          obs_beats.push_back(mem_wdata);
          m_k++;
          if (m_k == BEATS) m_done = cyc + 1;
        end
      end

`ifdef DCACHE_CRIT_WORD_EN
      chk("crit_valid", crit_valid, cyc == m_crit_cyc + 1);
      if (cyc == m_crit_cyc + 1) begin
        chk("crit_data", crit_data, m_crit_data);
        last_crit_data = crit_data;
      end
`endif

      if (m_active && !m_is_wb && (cyc > m_acc) && (m_k < BEATS) && mem_rvalid) begin
        m_line[64*m_k +: 64] = mem_rdata;
        if (m_k == int'(m_crit_word)) begin
          m_crit_cyc  = cyc;
          m_crit_data = mem_rdata;
        end
        m_k++;
        if (m_k == BEATS) begin
          m_wr = cyc + 1;
          m_done = cyc + 2;
          last_beat4_cyc = cyc;
        end
      end

      if (exp_done) m_active = 1'b0;

      if (!was_active && (wb_req || fill_req)) begin
        m_active = 1'b1;
        m_is_wb  = wb_req;
        m_acc    = cyc;
        m_set    = set_idx;
        m_k      = 0;
        m_wr     = BIG;
        m_done   = BIG;
        m_line   = '0;
        m_wbline = arr_mem[set_idx];
        last_acc_cyc = cyc;
`ifdef DCACHE_CRIT_WORD_EN
        m_crit_word = wb_req ? 2'd3 : crit_word;
        if (wb_req) m_crit_word = 2'd0;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int prev, input int maxc, input string nm);
    for (int i = 0; i < maxc && done_count == prev; i++) tick();
    chk(nm, done_count - prev, 1);
  endtask

  task automatic send_beat(input logic [63:0] d);
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  logic [255:0] line_l;
  logic [63:0]  bt [4];
  int d0, w0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      pl_en  = 1'b1;
      pl_idx = 4'(i);
      pl_val = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    pl_en = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_csb", arr_csb, 1'b1);
    chk("rst_web", arr_web, 1'b1);
    chk("rst_wmask", arr_wmask, 32'h0);
    chk("rst_wvalid", mem_wvalid, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Fill set 5 with gapped beats.
    bt[0] = 64'h1111_1111_1111_1111;
    bt[1] = 64'h2222_2222_2222_2222;
    bt[2] = 64'h3333_3333_3333_3333;
    bt[3] = 64'h4444_4444_4444_4444;
    d0 = done_count; w0 = wr_count;
`ifdef DCACHE_CRIT_WORD_EN
    crit_word = 2'd2;
`endif
    set_idx = 4'd5; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(bt[i]);
    wait_done(d0, 20, "fill5_done");
    tick(); tick();
    chk("fill5_one_done", done_count - d0, 1);
    chk("fill5_writes", wr_count - w0, 1);
    chk("fill5_addr", last_wr_addr, 4'd5);
    chk("fill5_mask", last_wr_mask, 32'hFFFF_FFFF);
    chk("fill5_din", last_wr_din,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    chk("fill5_latency", last_done_cyc - last_beat4_cyc, 2);
`ifdef DCACHE_CRIT_WORD_EN
    chk("fill5_crit", last_crit_data, 64'h3333_3333_3333_3333);
`endif

    // Writeback set 9 with a known line and toggling wready.
    line_l = 256'hFEDCBA9876543210_0123456789ABCDEF_A5A5A5A55A5A5A5A_0F1E2D3C4B5A6978;
    pl_en = 1'b1; pl_idx = 4'd9; pl_val = line_l;
    tick();
    pl_en = 1'b0;
    obs_beats.delete();
    d0 = done_count;
    set_idx = 4'd9; wb_req = 1'b1;
    tick();
    wb_req = 1'b0;
    for (int i = 0; i < 40 && done_count == d0; i++) begin
      mem_wready = ~mem_wready;
      tick();
    end
    chk("wb9_done", done_count - d0, 1);
    chk("wb9_nbeats", obs_beats.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("wb9_beat", (obs_beats.size() > i) ? obs_beats[i] : 64'h0, line_l[64*i +: 64]);

    // Simultaneous requests: writeback wins; a fill while busy is dropped.
    mem_wready = 1'b1;
    d0 = done_count; w0 = wr_count;
    set_idx = 4'd3; wb_req = 1'b1; fill_req = 1'b1;
    tick();
    wb_req = 1'b0; fill_req = 1'b0;
    tick();
    set_idx = 4'd7; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    wait_done(d0, 20, "both_done");
    chk("both_latency", last_done_cyc - last_acc_cyc, 7);
    tick(); tick(); tick();
    chk("both_no_write", wr_count - w0, 0);
    chk("both_idle", busy, 1'b0);

    // Reset in the middle of a fill, then a clean fill.
    w0 = wr_count;
    set_idx = 4'd2; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    send_beat(64'hDEAD_0000_0000_0001);
    send_beat(64'hDEAD_0000_0000_0002);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_csb", arr_csb, 1'b1);
    chk("midrst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_no_write", wr_count - w0, 0);
    d0 = done_count;
    set_idx = 4'd2; fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    send_beat(64'hAAAA_AAAA_AAAA_AAAA);
    send_beat(64'hBBBB_BBBB_BBBB_BBBB);
    send_beat(64'hCCCC_CCCC_CCCC_CCCC);
    send_beat(64'hDDDD_DDDD_DDDD_DDDD);
    wait_done(d0, 20, "refill_done");
    chk("refill_addr", last_wr_addr, 4'd2);
    chk("refill_din", last_wr_din,
        256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA);
    chk("refill_writes", wr_count - w0, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      fill_req   = ($urandom_range(0, 5) == 0);
      wb_req     = ($urandom_range(0, 7) == 0);
      set_idx    = 4'($urandom_range(0, 15));
      mem_rvalid = $urandom_range(0, 1) == 1;
      mem_rdata  = {$urandom, $urandom};
      mem_wready = $urandom_range(0, 9) < 6;
`ifdef DCACHE_CRIT_WORD_EN
      crit_word  = 2'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    fill_req = 1'b0; wb_req = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_line_buffer.md
DCACHE_LINE_BUFFER -- requirements
Module: dcache_line_buffer

Interface
REQ-001 SHALL have parameter BEATS, default 4, meaning the number of 64-bit memory beats per 256-bit line.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port fill_req, input, 1: start a line fill into set set_idx.
REQ-005 SHALL have port wb_req, input, 1: start a writeback of set set_idx.
REQ-006 SHALL have port set_idx, input, 4: target set, latched on request acceptance.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port mem_rdata, input, 64, and port mem_rvalid, input, 1: fill beats from memory.
REQ-010 SHALL have port mem_wdata, output, 64; port mem_wvalid, output, 1; port mem_wready, input, 1: writeback beats to memory.
REQ-011 SHALL have data-array ports arr_csb (out, 1, active low), arr_web (out, 1, active low), arr_wmask (out, 32), arr_addr (out, 4), arr_din (out, 256), arr_dout (in, 256).
REQ-012 SHALL have port crit_word, input, 2, and ports crit_valid (out, 1), crit_data (out, 64), present only when DCACHE_CRIT_WORD_EN is defined.

Function
REQ-013 SHALL implement states IDLE, FILL, FILL_WR, WB_RD, WB_CAP, WB_SEND, DONE.
REQ-014 IDLE: wb_req takes priority over fill_req if both are high; fill_req moves to FILL; wb_req moves to WB_RD; requests SHALL be ignored in all other states.
REQ-015 FILL: each cycle with mem_rvalid high SHALL store mem_rdata into beat slot k (bits 64k+63:64k), k counting 0..BEATS-1 and then wrapping; after beat BEATS-1, move to FILL_WR.
REQ-016 mem_rvalid outside FILL SHALL be ignored.
REQ-017 FILL_WR: drive arr_csb=0, arr_web=0, arr_wmask all ones, arr_addr=latched set, arr_din=assembled line for exactly one cycle, then DONE.
REQ-018 WB_RD: drive arr_csb=0, arr_web=1, arr_addr=latched set for one cycle, then WB_CAP.
REQ-019 WB_CAP: register arr_dout into the line buffer at the cycle's rising edge exit, then WB_SEND with k=0.
REQ-020 WB_SEND: mem_wvalid=1, mem_wdata=beat k, held stable until mem_wready; on handshake k increments; after handshake of beat BEATS-1, move to DONE.
REQ-021 DONE: done=1 for one cycle, then IDLE.
REQ-022 Outside FILL_WR/WB_RD: arr_csb=1, arr_web=1, arr_wmask=0; mem_wvalid=0 outside WB_SEND.
REQ-023 Latency: fill done = 2 cycles after the 4th beat; writeback with mem_wready tied high, done = 7 cycles after request.

Reset
REQ-024 rst SHALL immediately force state IDLE, beat counter 0, busy=0, done=0, arr_csb=1, arr_web=1, arr_wmask=0, mem_wvalid=0, crit_valid=0; line buffer contents don't-care.
REQ-025 rst mid-fill or mid-writeback SHALL discard the partial transfer; no array write is issued.

Configuration
REQ-026 With DCACHE_CRIT_WORD_EN defined: crit_word latched at fill_req; when beat k==crit_word arrives, crit_valid=1 and crit_data=mem_rdata registered for exactly one cycle.
REQ-027 Without DCACHE_CRIT_WORD_EN: crit ports and logic absent; all other behaviour identical.

Structure
REQ-028 State enum, LINE_W=256, BEAT_W=64, SET_W=4 SHALL live in a shared dcache package.
REQ-029 SHALL be a single module; the beat counter may optionally be a sub-module named dcache_beat_counter.

Verification
REQ-030 Fill set 5 with beats 0x11..,0x22..,0x33..,0x44.. (gaps between beats) -> one array write, addr 5, wmask 0xFFFFFFFF, din = {0x44..,0x33..,0x22..,0x11..}; done one pulse.
REQ-031 Writeback set 9, arr_dout model = line L, mem_wready toggling 1/0 -> 4 beats L[63:0]..L[255:192] in order, each held until handshake; done after the 4th.
REQ-032 fill_req and wb_req together in IDLE -> writeback executes; later fill_req while busy -> ignored.
REQ-033 rst asserted after 2 fill beats -> arr_csb stays 1, busy=0 immediately; new fill completes correctly with fresh beats.
REQ-034 DCACHE_CRIT_WORD_EN, crit_word=2 -> crit_valid pulses one cycle with 3rd beat data; not defined -> elaborates without crit ports.
